uart_tx_framer: RTL

- UART transmit framer, directly downstream of the baud-rate clock divisor.
- Takes parallel bytes over a valid/ready handshake and serialises each as an asynchronous frame: start, data LSB-first, optional parity, stop bit(s).
- Bit timing comes from baudTick, a one-clkIn-cycle strobe per bit period that the baud-rate stage derives from its divided output.
- The whole block runs on clkIn; no logic is clocked by the divided clock.

---
 rtl/uart_tx_framer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/uart_tx_framer.sv
// UART transmit framer: serialises parallel words as start / data LSB-first / parity / stop frames.
// Latency: start bit begins on the first baudTick strictly after the accepting clkIn edge.
// Backpressure: dataReady is high only in IDLE; dataValid is ignored while a frame is pending.
module uart_tx_framer #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clkIn,
   input  logic                 rst,
   input  logic                 baudTick,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 dataValid,
   output logic                 dataReady,
   output logic                 tx,
   output logic                 busy
);

   // Counter sizing: bitCnt must reach DATA_BITS-1 without wrapping.
   localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

   // Unrecognised PARITY values fall back to no parity.
   localparam logic PAR_EN  = (PARITY == 1) || (PARITY == 2);
   localparam logic PAR_ODD = (PARITY == 1);

   // stopCnt is a single bit, so two stop bits terminate at count 1.
   localparam logic LAST_STOP = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      START,
      DATA,
      PAR,
      STOP
   } state_t;

   state_t               state;
   logic [DATA_BITS-1:0] shiftReg;
   logic [CNT_W-1:0]     bitCnt;
   logic                 stopCnt;
   logic                 parityBit;

   assign dataReady = (state == IDLE);
   assign busy      = (state != IDLE);

   // Frame sequencer: captures a word in IDLE, then advances one bit per baudTick.
   always_ff @(posedge clkIn or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shiftReg  <= '0;
         bitCnt    <= '0;
         stopCnt   <= 1'b0;
         parityBit <= 1'b0;
         tx        <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               // A tick coincident with acceptance is deliberately not used;
               // SYNC waits for the next one so the start bit is a full period.
               if (dataValid) begin
                  shiftReg  <= data;
                  parityBit <= (^data) ^ PAR_ODD;
                  state     <= SYNC;
               end
            end
            SYNC: begin
               if (baudTick) begin
                  tx    <= 1'b0;
                  state <= START;
               end
            end
            START: begin
               if (baudTick) begin
                  tx     <= shiftReg[0];
                  bitCnt <= '0;
                  state  <= DATA;
               end
            end
            DATA: begin
               if (baudTick) begin
                  if (bitCnt != LAST_BIT) begin
                     shiftReg <= shiftReg >> 1;
                     tx       <= shiftReg[1];
                     bitCnt   <= bitCnt + CNT_W'(1);
                  end else if (PAR_EN) begin
                     tx    <= parityBit;
                     state <= PAR;
                  end else begin
                     tx      <= 1'b1;
                     stopCnt <= 1'b0;
                     state   <= STOP;
                  end
               end
            end
            PAR: begin
               if (baudTick) begin
                  tx      <= 1'b1;
                  stopCnt <= 1'b0;
                  state   <= STOP;
               end
            end
            STOP: begin
               // tx is already high; just count out the stop periods.
               if (baudTick) begin
                  if (stopCnt != LAST_STOP) begin
                     stopCnt <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule
